perf_counter_ctrl: RTL and testbench
====================================

// Module: perf_counter_ctrl
// PURPOSE
//  Hardware performance-counter controller for the pipelined core. Counts cycles,
//  retired instructions, control-transfer instructions and mispredictions from the
//  pipeline debug strobes. Sequences counting through IDLE/RUN/FROZEN under
//  software control and auto-freezes at a configured stop PC. Counters are read
//  back over a small registered register bus.
// PARAMETERS
//  CNT_W    32      counter width, legal 8..32; reads zero-extend to 32 bits
//  STOP_PC  32'h1C  PC whose valid retirement triggers auto-stop
// PORTS
//  i_clk       in   1   clock; all logic on rising edge
//  i_reset     in   1   synchronous, active-high reset
//  i_insn_vld  in   1   retired instruction valid this cycle
//  i_ctrl      in   1   retired instruction is a control transfer
//  i_mispred   in   1   misprediction resolved this cycle
//  i_pc        in   32  PC of the retiring instruction
//  i_addr      in   3   register word index
//  i_wren      in   1   write strobe
//  i_wdata     in   32  write data
//  i_rden      in   1   read strobe
//  o_rdata     out  32  read data, valid when o_rvld
//  o_rvld      out  1   read data valid, 1 cycle after i_rden
//  o_running   out  1   state == RUN
//  o_done      out  1   1-cycle pulse on auto-stop RUN->FROZEN
// BEHAVIOUR
//  Reset: state IDLE; counters, ovf flags, CTRL = 0; o_rdata=0, o_rvld=0, o_done=0.
//  Reg map: 0 CTRL RW [0]EN [1]CLR (self-clearing, reads 0) [2]AUTOSTOP;
//   1 STATUS RO [1:0]state (0 IDLE,1 RUN,2 FROZEN) [7:4]ovf{mis,ctl,insn,cyc};
//   2 CYCLE, 3 INSN, 4 CTRLCNT, 5 MISPRED (RO); 6,7 read 0.
//   Writes to RO or unmapped addresses are ignored.
//  FSM:
//   IDLE->RUN on CTRL write with EN=1.
//   RUN->FROZEN on CTRL write with EN=0, or on auto-stop
//    (AUTOSTOP && i_insn_vld && i_pc==STOP_PC); auto-stop pulses o_done next cycle.
//   FROZEN->RUN on CTRL write with EN=1; counting resumes from the held values.
//   Any state: a CLR write zeroes all counters and ovf flags. Next state is RUN
//    if the same write sets EN=1, else IDLE. CLR has priority over auto-stop.
//  Counting only in RUN.
//   CYCLE +1 every cycle; INSN +1 on i_insn_vld; CTRLCNT +1 on i_ctrl;
//    MISPRED +1 on i_mispred. i_ctrl/i_mispred are not qualified by i_insn_vld.
//   The auto-stop cycle itself is counted, including the stop instruction.
//    Counters hold from the following cycle.
//   A software EN=0 write cycle is also counted.
//  Saturation: a counter at all-ones holds and sets its sticky ovf flag.
//   The flag clears only on CLR or reset.
//  Read: registered, latency 1. o_rvld=1 exactly one cycle after i_rden.
//   o_rdata = register value before the edge at which i_rden is sampled.
//   A same-cycle write returns the old value. o_rdata holds when o_rvld=0.
//  Simultaneous read+write to the same address is legal. Back-to-back reads
//   are supported at 1 per cycle.
//  Reset mid-RUN: all state returns to reset values on the next edge;
//   o_rvld for an in-flight read is dropped.
// TESTING
//  1. Reset, write CTRL=1, run 10 cycles with i_insn_vld=1, write CTRL=0.
//     -> CYCLE=11, INSN=11, STATUS[1:0]=2.
//  2. CTRL=5 (EN|AUTOSTOP), retire PCs 0x0,0x4,..,0x1C.
//     -> o_done pulses once after the 0x1C retirement; INSN=8; counters hold after.
//  3. CNT_W=8, RUN 300 cycles.
//     -> CYCLE=0xFF, STATUS[4]=1; CLR write -> all zero, ovf=0, state IDLE.
//  4. In FROZEN, write CTRL=3 (CLR|EN).
//     -> counters zero, state RUN, CYCLE=1 after one more cycle.
//  5. Assert i_rden addr 2 on the same cycle as an event.
//     -> o_rvld next cycle with the pre-increment value; addr 6 reads 0.
//  6. Assert i_reset while RUN with a read pending.
//     -> o_rvld=0, state IDLE, all counters 0.

Source files
------------

// File: rtl/perf_counter_ctrl.sv
// Performance-counter controller: cycle/insn/ctrl/mispredict counters sequenced
// by an IDLE/RUN/FROZEN FSM, with auto-stop at a fixed PC and a registered read bus.
module perf_counter_ctrl #(
  parameter int unsigned CNT_W   = 32,
  parameter logic [31:0] STOP_PC = 32'h1C
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_insn_vld,
  input  logic        i_ctrl,
  input  logic        i_mispred,
  input  logic [31:0] i_pc,
  input  logic [2:0]  i_addr,
  input  logic        i_wren,
  input  logic [31:0] i_wdata,
  input  logic        i_rden,
  output logic [31:0] o_rdata,
  output logic        o_rvld,
  output logic        o_running,
  output logic        o_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FROZEN = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_en;
  logic        r_autostop;
  logic [31:0] r_rdata;
  logic        r_rvld;
  logic        r_done;

  logic        w_ctrl_wr;
  logic        w_clr;
  logic        w_run;
  logic        w_stop;
  logic [3:0]  w_evt;
  logic [3:0]  w_ovf;
  logic [31:0] w_cnt_ext [4];
  logic [31:0] w_rd_mux;
  logic        w_unused;

  assign w_ctrl_wr = i_wren && (i_addr == 3'd0);
  assign w_clr     = w_ctrl_wr && i_wdata[1];
  assign w_run     = (r_state == S_RUN);
  // A CLR write in the same cycle overrides the auto-stop trigger.
  assign w_stop    = w_run && r_autostop && i_insn_vld && (i_pc == STOP_PC) && !w_clr;
  assign w_evt     = {i_mispred, i_ctrl, i_insn_vld, 1'b1};
  assign w_unused  = &{1'b0, i_wdata[31:3]};

  // Index 0 cycle, 1 insn, 2 ctrl, 3 mispred; each saturates with a sticky flag.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    logic [CNT_W-1:0] r_val;
    logic             r_sat;

    always_ff @(posedge i_clk) begin
      if (i_reset || w_clr) begin
        r_val <= '0;
        r_sat <= 1'b0;
      end else if (w_run && w_evt[gi]) begin
        if (&r_val) begin
          r_sat <= 1'b1;
        end else begin
          r_val <= r_val + CNT_W'(1);
        end
      end
    end

    assign w_cnt_ext[gi] = 32'(r_val);
    assign w_ovf[gi]     = r_sat;
  end

  always_comb begin
    w_rd_mux = '0;
    case (i_addr)
      3'd0:    w_rd_mux = {29'd0, r_autostop, 1'b0, r_en};
      3'd1:    w_rd_mux = {24'd0, w_ovf, 2'b00, r_state};
      3'd2:    w_rd_mux = w_cnt_ext[0];
      3'd3:    w_rd_mux = w_cnt_ext[1];
      3'd4:    w_rd_mux = w_cnt_ext[2];
      3'd5:    w_rd_mux = w_cnt_ext[3];
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_en       <= 1'b0;
      r_autostop <= 1'b0;
      r_rdata    <= '0;
      r_rvld     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rvld <= i_rden;
      if (i_rden) begin
        r_rdata <= w_rd_mux;
      end
      r_done <= w_stop;

      if (w_ctrl_wr) begin
        r_en       <= i_wdata[0];
        r_autostop <= i_wdata[2];
      end

      if (w_clr) begin
        r_state <= i_wdata[0] ? S_RUN : S_IDLE;
      end else if (w_stop) begin
        r_state <= S_FROZEN;
      end else if (w_ctrl_wr) begin
        case (r_state)
          S_IDLE:   if (i_wdata[0])  r_state <= S_RUN;
          S_RUN:    if (!i_wdata[0]) r_state <= S_FROZEN;
          S_FROZEN: if (i_wdata[0])  r_state <= S_RUN;
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_rdata   = r_rdata;
  assign o_rvld    = r_rvld;
  assign o_running = (r_state == S_RUN);
  assign o_done    = r_done;

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Bench for perf_counter_ctrl: 32-bit and 8-bit instances share stimulus and are
// compared every cycle against a behavioural model; directed scenarios then random traffic.
module tb_perf_counter_ctrl;

  localparam logic [31:0] STOP = 32'h1C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, insn_vld, ctrl, mispred, wren, rden;
  logic [31:0] pc, wdata;
  logic [2:0]  addr;
  logic [31:0] rdata_a, rdata_b;
  logic        rvld_a, rvld_b, running_a, running_b, done_a, done_b;

  perf_counter_ctrl #(.CNT_W(32), .STOP_PC(STOP)) dut_a (
    .i_clk(clk), .i_reset(reset), .i_insn_vld(insn_vld), .i_ctrl(ctrl),
    .i_mispred(mispred), .i_pc(pc), .i_addr(addr), .i_wren(wren),
    .i_wdata(wdata), .i_rden(rden), .o_rdata(rdata_a), .o_rvld(rvld_a),
    .o_running(running_a), .o_done(done_a)
  );

  perf_counter_ctrl #(.CNT_W(8), .STOP_PC(STOP)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_insn_vld(insn_vld), .i_ctrl(ctrl),
    .i_mispred(mispred), .i_pc(pc), .i_addr(addr), .i_wren(wren),
    .i_wdata(wdata), .i_rden(rden), .o_rdata(rdata_b), .o_rvld(rvld_b),
    .o_running(running_b), .o_done(done_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: state 0 IDLE, 1 RUN, 2 FROZEN; counters kept as plain integers.
  int              m_state;
  bit              m_en, m_auto, m_done, m_rvld;
  longint unsigned m_cnt [2][4];
  bit              m_ovf [2][4];
  logic [31:0]     m_rdata [2];
  longint unsigned m_max [2];

  function automatic logic [31:0] m_read(input int w, input logic [2:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      3'd0: v = {29'd0, m_auto, 1'b0, m_en};
      3'd1: begin
        v = 32'(m_state);
        for (int i = 0; i < 4; i++) if (m_ovf[w][i]) v[4+i] = 1'b1;
      end
      3'd2, 3'd3, 3'd4, 3'd5: v = 32'(m_cnt[w][a - 3'd2]);
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_step();
    logic [31:0] rd [2];
    bit          wr_ctrl, clr, stop;
    bit          evt [4];
    if (reset) begin
      m_state = 0; m_en = 0; m_auto = 0; m_done = 0; m_rvld = 0;
      for (int w = 0; w < 2; w++) begin
        m_rdata[w] = '0;
        for (int i = 0; i < 4; i++) begin
          m_cnt[w][i] = 0;
          m_ovf[w][i] = 0;
        end
      end
      return;
    end
    for (int w = 0; w < 2; w++) rd[w] = m_read(w, addr);
    wr_ctrl = wren && (addr == 3'd0);
    clr     = wr_ctrl && wdata[1];
    stop    = (m_state == 1) && m_auto && insn_vld && (pc == STOP) && !clr;
    evt     = '{1'b1, insn_vld, ctrl, mispred};
    for (int w = 0; w < 2; w++) begin
      if (rden) m_rdata[w] = rd[w];
      for (int i = 0; i < 4; i++) begin
        if (clr) begin
          m_cnt[w][i] = 0;
          m_ovf[w][i] = 0;
        end else if (m_state == 1 && evt[i]) begin
          if (m_cnt[w][i] == m_max[w]) m_ovf[w][i] = 1;
          else m_cnt[w][i] = m_cnt[w][i] + 1;
        end
      end
    end
    m_rvld = rden;
    m_done = stop;
    if (clr) m_state = wdata[0] ? 1 : 0;
    else if (stop) m_state = 2;
    else if (wr_ctrl) begin
      if (wdata[0] && m_state != 1) m_state = 1;
      else if (!wdata[0] && m_state == 1) m_state = 2;
    end
    if (wr_ctrl) begin
      m_en   = wdata[0];
      m_auto = wdata[2];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("rvld_a", 32'(rvld_a), 32'(m_rvld));
    check_eq("rvld_b", 32'(rvld_b), 32'(m_rvld));
    check_eq("rdata_a", rdata_a, m_rdata[0]);
    check_eq("rdata_b", rdata_b, m_rdata[1]);
    check_eq("done_a", 32'(done_a), 32'(m_done));
    check_eq("done_b", 32'(done_b), 32'(m_done));
    check_eq("running_a", 32'(running_a), 32'(m_state == 1));
    check_eq("running_b", 32'(running_b), 32'(m_state == 1));
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [31:0] va, output logic [31:0] vb);
    rden = 1'b1;
    addr = a;
    tick();
    rden = 1'b0;
    va = rdata_a;
    vb = rdata_b;
    $display("read  addr=%0d w32=0x%08h w8=0x%08h", a, va, vb);
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    wren  = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    wren  = 1'b0;
    $display("write addr=%0d data=0x%08h", a, d);
  endtask

  initial begin
    logic [31:0] va, vb;
    m_max[0] = 64'hFFFF_FFFF;
    m_max[1] = 64'hFF;
    reset = 1; insn_vld = 0; ctrl = 0; mispred = 0; pc = '0;
    wren = 0; wdata = '0; addr = '0; rden = 0;
    tick();
    tick();
    reset = 0;
    read_reg(3'd1, va, vb);
    check_eq("rst_status", va, 32'h0);
    read_reg(3'd2, va, vb);
    check_eq("rst_cycle", va, 32'h0);

    // 1: enable, 10 running cycles, disable (disable cycle is counted)
    insn_vld = 1;
    write_reg(3'd0, 32'h1);
    repeat (10) tick();
    write_reg(3'd0, 32'h0);
    insn_vld = 0;
    read_reg(3'd2, va, vb);
    check_eq("t1_cycle", va, 32'd11);
    check_eq("t1_cycle8", vb, 32'd11);
    read_reg(3'd3, va, vb);
    check_eq("t1_insn", va, 32'd11);
    read_reg(3'd1, va, vb);
    check_eq("t1_status", va, 32'd2);

    // 2: auto-stop at STOP after retiring 0x0..0x1C
    write_reg(3'd0, 32'h2);
    write_reg(3'd0, 32'h5);
    for (int k = 0; k < 8; k++) begin
      insn_vld = 1;
      pc = 32'(k * 4);
      tick();
    end
    check_eq("t2_done_pulse", 32'(done_a), 32'h1);
    pc = 32'h20;
    tick();
    check_eq("t2_done_low", 32'(done_a), 32'h0);
    tick();
    insn_vld = 0;
    read_reg(3'd3, va, vb);
    check_eq("t2_insn", va, 32'd8);
    read_reg(3'd2, va, vb);
    check_eq("t2_cycle_hold", va, 32'd8);
    read_reg(3'd1, va, vb);
    check_eq("t2_status", va, 32'd2);

    // 3: saturation of the 8-bit instance, then CLR
    write_reg(3'd0, 32'h3);
    repeat (300) tick();
    write_reg(3'd0, 32'h0);
    read_reg(3'd2, va, vb);
    check_eq("t3_cycle32", va, 32'd301);
    check_eq("t3_cycle8_sat", vb, 32'hFF);
    read_reg(3'd1, va, vb);
    check_eq("t3_status32", va, 32'h02);
    check_eq("t3_status8_ovf", vb, 32'h12);
    write_reg(3'd0, 32'h2);
    read_reg(3'd2, va, vb);
    check_eq("t3_clr_cycle8", vb, 32'h0);
    read_reg(3'd1, va, vb);
    check_eq("t3_clr_status8", vb, 32'h0);

    // 4: CLR|EN from FROZEN restarts counting from zero
    write_reg(3'd0, 32'h1);
    repeat (3) tick();
    write_reg(3'd0, 32'h0);
    write_reg(3'd0, 32'h3);
    check_eq("t4_running", 32'(running_a), 32'h1);
    tick();
    read_reg(3'd2, va, vb);
    check_eq("t4_cycle", va, 32'd1);

    // 5: reads coinciding with events, back-to-back, same-cycle write, unmapped
    insn_vld = 1;
    ctrl = 1;
    read_reg(3'd2, va, vb);
    check_eq("t5_pre_inc", va, 32'd2);
    read_reg(3'd2, va, vb);
    check_eq("t5_b2b", va, 32'd3);
    read_reg(3'd3, va, vb);
    check_eq("t5_insn", va, 32'd2);
    read_reg(3'd4, va, vb);
    check_eq("t5_ctrlcnt", va, 32'd3);
    insn_vld = 0;
    ctrl = 0;
    wren = 1; rden = 1; addr = 3'd0; wdata = 32'h5;
    tick();
    wren = 0; rden = 0;
    check_eq("t5_rw_old", rdata_a, 32'h1);
    read_reg(3'd0, va, vb);
    check_eq("t5_rw_new", va, 32'h5);
    read_reg(3'd6, va, vb);
    check_eq("t5_addr6", va, 32'h0);

    // 6: reset while running with a read in flight
    rden = 1; addr = 3'd2; reset = 1;
    tick();
    reset = 0; rden = 0;
    check_eq("t6_rvld", 32'(rvld_a), 32'h0);
    check_eq("t6_running", 32'(running_a), 32'h0);
    read_reg(3'd2, va, vb);
    check_eq("t6_cycle", va, 32'h0);
    read_reg(3'd1, va, vb);
    check_eq("t6_status", va, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      reset    = ($urandom_range(0, 299) == 0);
      insn_vld = ($urandom_range(0, 3) != 0);
      ctrl     = ($urandom_range(0, 3) == 0);
      mispred  = ($urandom_range(0, 7) == 0);
      pc       = 32'($urandom_range(0, 7)) << 2;
      wren     = ($urandom_range(0, 3) == 0);
      addr     = 3'($urandom_range(0, 7));
      wdata    = $urandom;
      if ($urandom_range(0, 3) != 0) wdata[1] = 1'b0;
      rden     = ($urandom_range(0, 1) == 1);
      tick();
    end
    reset = 0; wren = 0; rden = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
